// File: rtl/sound_event_arbiter_pkg.sv
// sound_arb_pkg -- shared types and constants for the sound event arbiter.
//   state_t            : arbiter FSM states
//   DEF_NUM_REQ        : default number of requesters (index 0 = highest priority)
//   DEF_SEL_W          : default melodySelect width
//   DEF_TIMEOUT_TICKS  : default watchdog limit in 10 ms ticks (10 s)
//   WD_W               : watchdog counter width (saturating, never wraps)
//   melody_of_req()    : melody code launched for each requester
package sound_arb_pkg;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_SEL_W         = 4;
  localparam int DEF_TIMEOUT_TICKS = 1000;
  localparam int WD_W              = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_PLAY   = 2'd2,
    S_ABORT  = 2'd3
  } state_t;

  // Requester index -> melody code understood by the player.
  function automatic logic [DEF_SEL_W-1:0] melody_of_req(input int unsigned idx);
    logic [DEF_SEL_W-1:0] code;
    case (idx)
      32'd0:   code = 4'h3;  // gold caught
      32'd1:   code = 4'h5;  // rock caught
      32'd2:   code = 4'h9;  // level end
      32'd3:   code = 4'hC;  // timer low
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sound_event_arbiter_if.sv
// sound_event_arbiter_if -- game-logic / melody-player side signals of the arbiter.
//   master modport : game logic + player model (drives requests, tick, enable, melodyEnded)
//   slave modport  : the arbiter (drives launch pulse, selection, abort, status)
//   hundredthSecPulse, enable, req[NUM_REQ], melodyEnded            -> arbiter
//   startMelodyKey, melodySelect[SEL_W], playerResetN, busy,
//   activeReq[clog2(NUM_REQ)], timeoutErr                           <- arbiter
interface sound_event_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 4
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                hundredthSecPulse;
  logic                enable;
  logic [NUM_REQ-1:0]  req;
  logic                melodyEnded;
  logic                startMelodyKey;
  logic [SEL_W-1:0]    melodySelect;
  logic                playerResetN;
  logic                busy;
  logic [IDX_W-1:0]    activeReq;
  logic                timeoutErr;

  modport master (
    output hundredthSecPulse, enable, req, melodyEnded,
    input  startMelodyKey, melodySelect, playerResetN, busy, activeReq, timeoutErr
  );

  modport slave (
    input  hundredthSecPulse, enable, req, melodyEnded,
    output startMelodyKey, melodySelect, playerResetN, busy, activeReq, timeoutErr
  );
endinterface

// File: rtl/sound_event_arbiter_prio_encoder.sv
// prio_encoder -- lowest-index-first priority encoder.
//   i_vec   [N]      request vector
//   o_valid          at least one bit of i_vec set
//   o_idx   [IDX_W]  index of the lowest set bit (0 when none)
module prio_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_vec,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      o_valid = o_valid | i_vec[i];
      o_idx   = i_vec[i] ? IDX_W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/sound_event_arbiter.sv
// sound_event_arbiter -- shares the single melody-player channel between NUM_REQ
// game-event requesters. Requests are latched into a pending vector, granted by
// fixed priority (index 0 highest), launched with a one-clock startMelodyKey and
// held stable until the player pulses melodyEnded. A saturating 10 ms watchdog
// aborts a melody that never ends (playerResetN low for one clock, timeoutErr set).
// Ports:
//   CLOCK_31p5  system clock (31.5 MHz)
//   resetN      asynchronous active-low reset
//   bus         sound_event_arbiter_if.slave (requests in, player control out)
// Build option:
//   SOUND_ARB_PREEMPT_EN  when defined, a pending request of higher priority than
//                         the playing one aborts it and is launched instead.
module sound_event_arbiter
  import sound_arb_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int SEL_W         = DEF_SEL_W,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input logic                  CLOCK_31p5,
  input logic                  resetN,
  sound_event_arbiter_if.slave bus
);

  localparam int              IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_TICKS);
  localparam logic [WD_W-1:0] WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};

  state_t             r_state;
  logic [NUM_REQ-1:0] r_pending;
  logic [WD_W-1:0]    r_watchdog;
  logic               r_start;
  logic [SEL_W-1:0]   r_sel;
  logic               r_player_rst_n;
  logic               r_busy;
  logic [IDX_W-1:0]   r_active;
  logic               r_timeout_err;

  logic [NUM_REQ-1:0] w_pend_masked;
  logic               w_enc_valid;
  logic [IDX_W-1:0]   w_enc_idx;
  logic               w_grant_fire;
  logic [NUM_REQ-1:0] w_clr;
  logic [WD_W-1:0]    w_wd_next;

  // With enable low nothing pending is eligible, so no launch can happen.
  assign w_pend_masked = r_pending & {NUM_REQ{bus.enable}};
  assign w_grant_fire  = (r_state == S_IDLE) && w_enc_valid;

  prio_encoder #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .i_vec   (w_pend_masked),
    .o_valid (w_enc_valid),
    .o_idx   (w_enc_idx)
  );

`ifdef SOUND_ARB_PREEMPT_EN
  logic w_preempt;
  assign w_preempt = w_enc_valid && (w_enc_idx < r_active);
`endif

  // One-hot clear of the requester being granted this cycle.
  always_comb begin
    w_clr = {NUM_REQ{1'b0}};
    if (w_grant_fire) begin
      w_clr = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_enc_idx;
    end else begin
      w_clr = {NUM_REQ{1'b0}};
    end
  end

  // Saturating watchdog increment on each 10 ms tick.
  always_comb begin
    w_wd_next = r_watchdog;
    if (bus.hundredthSecPulse && (r_watchdog != WD_MAX)) begin
      w_wd_next = r_watchdog + WD_ONE;
    end else begin
      w_wd_next = r_watchdog;
    end
  end

  // Pending vector: a new request wins over a same-cycle grant clear (re-queue).
  always_ff @(posedge CLOCK_31p5 or negedge resetN) begin
    if (!resetN) begin
      r_pending <= {NUM_REQ{1'b0}};
    end else if (!bus.enable) begin
      r_pending <= {NUM_REQ{1'b0}};
    end else begin
      r_pending <= (r_pending & ~w_clr) | bus.req;
    end
  end

  // Arbiter FSM with registered player-control and status outputs.
  always_ff @(posedge CLOCK_31p5 or negedge resetN) begin
    if (!resetN) begin
      r_state        <= S_IDLE;
      r_watchdog     <= {WD_W{1'b0}};
      r_start        <= 1'b0;
      r_sel          <= {SEL_W{1'b0}};
      r_player_rst_n <= 1'b1;
      r_busy         <= 1'b0;
      r_active       <= {IDX_W{1'b0}};
      r_timeout_err  <= 1'b0;
    end else begin
      // Abort is a single-cycle low pulse; every other state releases it.
      r_player_rst_n <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_grant_fire) begin
            r_sel    <= SEL_W'(melody_of_req(32'(w_enc_idx)));
            r_active <= w_enc_idx;
            r_start  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_LAUNCH;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          r_start    <= 1'b0;
          r_watchdog <= {WD_W{1'b0}};
          r_state    <= S_PLAY;
        end
        S_PLAY: begin
          r_watchdog <= w_wd_next;
          // A melody that ends on the timeout cycle is treated as a clean end.
          if (bus.melodyEnded) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_watchdog == WD_LIMIT) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_ABORT;
          end
`ifdef SOUND_ARB_PREEMPT_EN
          // Pre-empted melody is dropped; its requester is not re-queued.
          else if (w_preempt) begin
            r_state <= S_ABORT;
          end
`endif
          else begin
            r_state <= S_PLAY;
          end
        end
        S_ABORT: begin
          r_player_rst_n <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.startMelodyKey = r_start;
  assign bus.melodySelect   = r_sel;
  assign bus.playerResetN   = r_player_rst_n;
  assign bus.busy           = r_busy;
  assign bus.activeReq      = r_active;
  assign bus.timeoutErr     = r_timeout_err;

endmodule

// File: tb/tb_sound_event_arbiter.sv
// tb_sound_event_arbiter -- directed, table-driven bench for sound_event_arbiter.
// Watchdog limit is shortened to 5 ticks; the tick is held high only in the
// timeout sequence. Pre-emption checks are built when SOUND_ARB_PREEMPT_EN is defined.
module tb_sound_event_arbiter;

  localparam logic [3:0] M0 = 4'h3;
  localparam logic [3:0] M1 = 4'h5;
  localparam logic [3:0] M2 = 4'h9;
  localparam logic [3:0] M3 = 4'hC;

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic       ended;
    logic       exp_start;
    logic [3:0] exp_sel;
    logic       exp_busy;
    logic [1:0] exp_act;
    logic       exp_prn;
    logic       exp_terr;
  } vec_t;

  logic clk;
  logic resetN;
  int   n_checks;
  int   n_errors;
  vec_t vecs[$];

  sound_event_arbiter_if bus ();

  sound_event_arbiter #(
    .NUM_REQ       (4),
    .SEL_W         (4),
    .TIMEOUT_TICKS (5)
  ) dut (
    .CLOCK_31p5 (clk),
    .resetN     (resetN),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic en, input logic ended,
                     input logic st, input logic [3:0] sel, input logic bsy,
                     input logic [1:0] act, input logic prn, input logic terr);
    vec_t v;
    v.req = req; v.en = en; v.ended = ended;
    v.exp_start = st; v.exp_sel = sel; v.exp_busy = bsy;
    v.exp_act = act; v.exp_prn = prn; v.exp_terr = terr;
    vecs.push_back(v);
  endtask

  task automatic chk_outputs(input int row, input logic st, input logic [3:0] sel, input logic bsy,
                             input logic [1:0] act, input logic prn, input logic terr);
    chk("startMelodyKey", row, 32'(bus.startMelodyKey), 32'(st));
    chk("melodySelect",   row, 32'(bus.melodySelect),   32'(sel));
    chk("busy",           row, 32'(bus.busy),           32'(bsy));
    chk("activeReq",      row, 32'(bus.activeReq),      32'(act));
    chk("playerResetN",   row, 32'(bus.playerResetN),   32'(prn));
    chk("timeoutErr",     row, 32'(bus.timeoutErr),     32'(terr));
  endtask

  initial begin
    logic [3:0] ls;
    logic [1:0] la;
    int         n;
    logic       saw_start;

    n_checks = 0;
    n_errors = 0;
    resetN = 1'b0;
    bus.req = 4'b0000;
    bus.enable = 1'b1;
    bus.melodyEnded = 1'b0;
    bus.hundredthSecPulse = 1'b0;

    // ---- vector table: one row = inputs for one clock, outputs after that edge
    // req0 alone
    add(4'b0001, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b1, M0,   1'b1, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, M0,   1'b1, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, M0,   1'b1, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b1, 1'b0, M0,   1'b0, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, M0,   1'b0, 2'd0, 1'b1, 1'b0);
    // req1 and req2 together: 1 first, then 2 right after the end
    add(4'b0110, 1'b1, 1'b0, 1'b0, M0,   1'b0, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b1, M1,   1'b1, 2'd1, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, M1,   1'b1, 2'd1, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b1, 1'b0, M1,   1'b0, 2'd1, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b1, M2,   1'b1, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, M2,   1'b1, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b1, 1'b0, M2,   1'b0, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, M2,   1'b0, 2'd2, 1'b1, 1'b0);
`ifndef SOUND_ARB_PREEMPT_EN
    // req3 during req0 playback: waits, no abort
    add(4'b0001, 1'b1, 1'b0, 1'b0, M2,   1'b0, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b1, M0,   1'b1, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, M0,   1'b1, 2'd0, 1'b1, 1'b0);
    add(4'b1000, 1'b1, 1'b0, 1'b0, M0,   1'b1, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, M0,   1'b1, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b1, 1'b0, M0,   1'b0, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b1, M3,   1'b1, 2'd3, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, M3,   1'b1, 2'd3, 1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b1, 1'b0, M3,   1'b0, 2'd3, 1'b1, 1'b0);
    ls = M3; la = 2'd3;
`else
    ls = M2; la = 2'd2;
`endif
    // enable low drops pending 1010; melodyEnded in idle is ignored
    add(4'b1010, 1'b1, 1'b0, 1'b0, ls,   1'b0, la,   1'b1, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, ls,   1'b0, la,   1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, ls,   1'b0, la,   1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b1, 1'b0, ls,   1'b0, la,   1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, ls,   1'b0, la,   1'b1, 1'b0);

    // ---- reset state
    cyc();
    cyc();
    chk_outputs(-1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    resetN = 1'b1;
    cyc();
    chk_outputs(0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);

    // ---- table
    for (int i = 0; i < vecs.size(); i++) begin
      bus.req         = vecs[i].req;
      bus.enable      = vecs[i].en;
      bus.melodyEnded = vecs[i].ended;
      cyc();
      chk_outputs(i + 1, vecs[i].exp_start, vecs[i].exp_sel, vecs[i].exp_busy,
                  vecs[i].exp_act, vecs[i].exp_prn, vecs[i].exp_terr);
    end
    bus.req = 4'b0000;
    bus.enable = 1'b1;
    bus.melodyEnded = 1'b0;

`ifdef SOUND_ARB_PREEMPT_EN
    // ---- pre-emption: req0 while req2 plays
    bus.req = 4'b0100; cyc(); bus.req = 4'b0000;
    cyc();
    chk("pre_launch2_start", 200, 32'(bus.startMelodyKey), 32'd1);
    chk("pre_launch2_sel",   200, 32'(bus.melodySelect),   32'(M2));
    cyc();
    bus.req = 4'b0001; cyc(); bus.req = 4'b0000;
    cyc();
    chk("pre_abort_wait_prn", 201, 32'(bus.playerResetN), 32'd1);
    cyc();
    chk("pre_abort_prn",  202, 32'(bus.playerResetN), 32'd0);
    chk("pre_abort_busy", 202, 32'(bus.busy),         32'd0);
    cyc();
    chk_outputs(203, 1'b1, M0, 1'b1, 2'd0, 1'b1, 1'b0);
    cyc();
    bus.melodyEnded = 1'b1; cyc(); bus.melodyEnded = 1'b0;
    chk("pre_end_busy", 204, 32'(bus.busy), 32'd0);
    saw_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      saw_start = saw_start | bus.startMelodyKey;
    end
    chk("pre_no_replay_req2", 205, 32'(saw_start), 32'd0);
`endif

    // ---- watchdog timeout with a tick every clock
    bus.hundredthSecPulse = 1'b1;
    bus.req = 4'b0001;
    n = 0;
    cyc(); n++;
    bus.req = 4'b0000;
    while (bus.playerResetN !== 1'b0 && n < 40) begin
      cyc(); n++;
    end
    chk("timeout_cycles", 300, 32'(n),               32'd10);
    chk("timeout_prn",    300, 32'(bus.playerResetN), 32'd0);
    chk("timeout_busy",   300, 32'(bus.busy),         32'd0);
    chk("timeout_err",    300, 32'(bus.timeoutErr),   32'd1);
    cyc();
    chk("timeout_prn_release", 301, 32'(bus.playerResetN), 32'd1);
    chk("timeout_err_sticky",  301, 32'(bus.timeoutErr),   32'd1);
    bus.hundredthSecPulse = 1'b0;
    cyc();

    // ---- reset mid-play drops pending and restores reset outputs
    bus.req = 4'b0110; cyc(); bus.req = 4'b0000;
    cyc();
    chk("rst_pre_start", 400, 32'(bus.startMelodyKey), 32'd1);
    chk("rst_pre_sel",   400, 32'(bus.melodySelect),   32'(M1));
    cyc();
    cyc();
    resetN = 1'b0;
    #2;
    chk_outputs(401, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc();
    resetN = 1'b1;
    saw_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      saw_start = saw_start | bus.startMelodyKey | bus.busy;
    end
    chk("rst_pending_dropped", 402, 32'(saw_start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
